prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Upstream program loader for the scheduler: receives a program image as a 16-bit valid/ready word stream,
//  writes it into the frame memory array, and drives prog_loading high while the image is being loaded.
//  Its memory array output feeds the scheduler's data_frames_in directly.
//  Stream format: a header word (image length N in words), then N data words, then one checksum word if enabled.
// PARAMETERS
//  DATA_DEPTH  1024  frame memory depth in words; power of two
//  INSTR_SIZE  16    word width; must equal the in_data width
//  LEN_W       11    header length field width, $clog2(DATA_DEPTH)+1
// PORTS
//  clk              in   1                      clock, rising edge
//  reset            in   1                      asynchronous, active-high
//  start            in   1                      1-cycle pulse that begins a load; honoured only in IDLE
//  in_valid         in   1                      stream word valid
//  in_data          in   INSTR_SIZE             stream word
//  in_ready         out  1                      loader accepts in_data this cycle
//  prog_loading     out  1                      load in progress; scheduler holds off dispatch
//  load_done        out  1                      1-cycle pulse when a load completes successfully
//  load_err         out  1                      sticky error flag; cleared by the next accepted start
//  words_loaded     out  LEN_W                  count of data words written in the current/last load
//  data_frames_out  out  [DATA_DEPTH][INSTR_SIZE]  frame memory contents, to scheduler data_frames_in
// BEHAVIOUR
//  - Reset (async): state=IDLE; in_ready, prog_loading, load_done, load_err = 0; words_loaded = 0;
//    write address = 0. data_frames_out is NOT reset (memory keeps its contents).
//  - Handshake: a word transfers on a rising clk edge where in_valid & in_ready. in_ready is registered
//    from state only and never depends on in_valid. in_data must be held stable while in_valid=1 and in_ready=0.
//  - FSM: IDLE -> HDR -> LOAD -> [CHK] -> DONE -> IDLE; any -> ERR -> IDLE.
//    IDLE: in_ready=0. On start: go to HDR; the next cycle prog_loading=1, in_ready=1, load_err=0,
//      words_loaded=0, address=0, checksum accumulator=0. start outside IDLE is ignored.
//    HDR: accept one word; len = in_data[LEN_W-1:0]; the remaining upper bits must be 0.
//      If len > DATA_DEPTH or upper bits != 0 -> ERR. If len == 0 -> CHK if enabled, otherwise DONE.
//      Otherwise -> LOAD.
//    LOAD: each accepted word is written to mem[address], then address+1 and words_loaded+1, and is XORed
//      into the accumulator. The written word appears on data_frames_out the cycle after acceptance.
//      The word that makes words_loaded == len -> CHK if enabled, otherwise DONE.
//    DONE: one cycle with in_ready=0; load_done=1 for this cycle only; prog_loading falls on exit to IDLE.
//    ERR: in_ready=0; prog_loading drops to 0 the next cycle; load_err=1 and is held until the next
//      start in IDLE. ERR moves to IDLE after one cycle. Words written before the error stay in memory.
//  - Address width is $clog2(DATA_DEPTH); it never wraps because len <= DATA_DEPTH is enforced.
//  - Memory locations at or above len keep their previous contents.
//  - Reset asserted mid-load: the load aborts immediately and the outputs take their reset values.
//    Partially written memory stays as written.
//  - start coinciding with reset: reset wins.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after the last data word, state CHK accepts one word.
//    If it equals the XOR of all N data words (0 when N=0), go to DONE; otherwise go to ERR.
//  LOADER_CHECKSUM_EN undefined: CHK state, accumulator and checksum word are absent;
//    LOAD/HDR go straight to DONE. A stream sending an extra word leaves it unaccepted (in_ready=0).
// TESTING
//  1. Reset, start, header 3, words A1B2,0003,FFFF (valid every cycle): mem[0..2]=A1B2,0003,FFFF,
//     words_loaded=3, one load_done pulse, prog_loading high from the cycle after start through DONE.
//  2. Header 0 without checksum: DONE on the cycle after the header; load_done=1; memory unchanged.
//  3. Header 1025 (DATA_DEPTH=1024): load_err=1, prog_loading falls, no memory write;
//     the next start clears load_err.
//  4. Random in_valid gaps, header 16, values 0..15: mem[0..15]=0..15, no duplicated or skipped words,
//     in_ready held for the entire LOAD state.
//  5. Assert reset after 5 of 10 words: all outputs return to reset values asynchronously;
//     mem[0..4] keep their written values.
//  6. With LOADER_CHECKSUM_EN, header 2, words 00F0,0F0F: checksum 0FFF -> load_done;
//     checksum 0000 -> load_err=1 and no load_done.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: accepts a program image as a 16-bit valid/ready word stream
// (header = length N, then N data words, then an optional checksum word),
// writes the data words into the frame memory and holds prog_loading high
// while the image is in flight. The frame memory drives data_frames_out.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   - a checksum word (XOR of all data words) follows the data and
//               is verified in state CHK before load_done.
//   undefined - no checksum word; the load completes after the last data word.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   start           one-cycle pulse that begins a load (honoured only in IDLE)
//   in_valid        stream word valid
//   in_data         stream word
//   in_ready        loader accepts in_data this cycle (registered, state only)
//   prog_loading    load in progress
//   load_done       one-cycle pulse on successful completion
//   load_err        sticky error flag, cleared by the next accepted start
//   words_loaded    data words written in the current/last load
//   data_frames_out frame memory contents (not reset)
module prog_loader #(
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned INSTR_SIZE = 16,
  parameter int unsigned LEN_W      = 11
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  in_valid,
  input  logic [INSTR_SIZE-1:0]                 in_data,
  output logic                                  in_ready,
  output logic                                  prog_loading,
  output logic                                  load_done,
  output logic                                  load_err,
  output logic [LEN_W-1:0]                      words_loaded,
  output logic [DATA_DEPTH-1:0][INSTR_SIZE-1:0] data_frames_out
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t                               r_state;
  logic                                 r_in_ready;
  logic                                 r_prog_loading;
  logic                                 r_load_done;
  logic                                 r_load_err;
  logic [LEN_W-1:0]                     r_words_loaded;
  logic [LEN_W-1:0]                     r_len;
  logic [AW-1:0]                        r_addr;
  logic [DATA_DEPTH-1:0][INSTR_SIZE-1:0] r_mem;
`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_SIZE-1:0]                r_acc;
`endif

  logic             w_xfer;
  logic [LEN_W-1:0] w_hdr_len;
  logic             w_hdr_bad;
  logic [LEN_W-1:0] w_wl_inc;
  logic             w_wr_en;

  // Handshake and header decode; upper header bits must be clear and the
  // length may not exceed the memory depth, so the address never wraps.
  assign w_xfer    = in_valid & r_in_ready;
  assign w_hdr_len = in_data[LEN_W-1:0];
  assign w_hdr_bad = (|in_data[INSTR_SIZE-1:LEN_W]) ||
                     (w_hdr_len > LEN_W'(DATA_DEPTH));
  assign w_wl_inc  = r_words_loaded + LEN_W'(1);
  assign w_wr_en   = (r_state == S_LOAD) && w_xfer;

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_prog_loading <= 1'b0;
      r_load_done    <= 1'b0;
      r_load_err     <= 1'b0;
      r_words_loaded <= '0;
      r_len          <= '0;
      r_addr         <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_acc          <= '0;
`endif
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_HDR;
            r_in_ready     <= 1'b1;
            r_prog_loading <= 1'b1;
            r_load_err     <= 1'b0;
            r_words_loaded <= '0;
            r_addr         <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_acc          <= '0;
`endif
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            if (w_hdr_bad) begin
              r_state        <= S_ERR;
              r_in_ready     <= 1'b0;
              r_prog_loading <= 1'b0;
              r_load_err     <= 1'b1;
            end else if (w_hdr_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state     <= S_CHK;
`else
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_load_done <= 1'b1;
`endif
            end else begin
              r_state <= S_LOAD;
              r_len   <= w_hdr_len;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_addr         <= r_addr + AW'(1);
            r_words_loaded <= w_wl_inc;
`ifdef LOADER_CHECKSUM_EN
            r_acc          <= r_acc ^ in_data;
`endif
            if (w_wl_inc == r_len) begin
`ifdef LOADER_CHECKSUM_EN
              r_state     <= S_CHK;
`else
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_load_done <= 1'b1;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (in_data == r_acc) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
            end else begin
              r_state        <= S_ERR;
              r_prog_loading <= 1'b0;
              r_load_err     <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          r_state        <= S_IDLE;
          r_prog_loading <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state        <= S_IDLE;
          r_in_ready     <= 1'b0;
          r_prog_loading <= 1'b0;
        end
      endcase
    end
  end

  // Frame memory: deliberately not reset so a partial image survives an abort.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_addr] <= in_data;
    end
  end

  assign in_ready        = r_in_ready;
  assign prog_loading    = r_prog_loading;
  assign load_done       = r_load_done;
  assign load_err        = r_load_err;
  assign words_loaded    = r_words_loaded;
  assign data_frames_out = r_mem;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed stream loads checked every cycle against a
// stream-position model, plus hand-computed literal expectations.
module tb_prog_loader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned IW    = 16;
  localparam int unsigned LW    = 11;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start = 1'b0;
  logic                       in_valid = 1'b0;
  logic [IW-1:0]              in_data = '0;
  logic                       in_ready;
  logic                       prog_loading;
  logic                       load_done;
  logic                       load_err;
  logic [LW-1:0]              words_loaded;
  logic [DEPTH-1:0][IW-1:0]   dfo;

  prog_loader #(.DATA_DEPTH(DEPTH), .INSTR_SIZE(IW), .LEN_W(LW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .prog_loading    (prog_loading),
    .load_done       (load_done),
    .load_err        (load_err),
    .words_loaded    (words_loaded),
    .data_frames_out (dfo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // Model: the stream is header, N data words, optional checksum. m_pos counts
  // stream words taken; m_phase: 0 idle, 1 streaming, 2 done cycle, 3 error cycle.
  int            m_phase = 0;
  int            m_pos   = 0;
  int            m_len   = 0;
  logic [IW-1:0] m_sum   = '0;
  bit            e_ready = 0, e_loading = 0, e_done = 0, e_err = 0;
  int            e_wl = 0;
  logic [IW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];

  task automatic finish_ok();
    m_phase = 2; e_ready = 0; e_done = 1;
  endtask

  task automatic enter_err();
    m_phase = 3; e_ready = 0; e_loading = 0; e_err = 1;
  endtask

  task automatic take_word(input logic [IW-1:0] w);
    int hi, l;
    if (m_pos == 0) begin
      hi = int'(w) / 2048;
      l  = int'(w) % 2048;
      if (hi != 0 || l > int'(DEPTH)) enter_err();
      else begin
        m_len = l;
        m_pos = 1;
        if (l == 0 && !CK) finish_ok();
      end
    end else if (m_pos <= m_len) begin
      m_mem[m_pos-1]   = w;
      m_known[m_pos-1] = 1;
      e_wl++;
      m_sum = m_sum ^ w;
      m_pos++;
      if (m_pos > m_len && !CK) finish_ok();
    end else begin
      if (w == m_sum) finish_ok();
      else enter_err();
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = 0; e_ready = 0; e_loading = 0; e_done = 0; e_err = 0; e_wl = 0;
      end else begin
        bit x;
        x = in_valid && e_ready;
        e_done = 0;
        case (m_phase)
          0: if (start) begin
               m_phase = 1; m_pos = 0; m_sum = '0;
               e_ready = 1; e_loading = 1; e_err = 0; e_wl = 0;
             end
          1: if (x) take_word(in_data);
          2: begin m_phase = 0; e_loading = 0; end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        int bad_i;
        check("in_ready", int'(in_ready), int'(e_ready));
        check("prog_loading", int'(prog_loading), int'(e_loading));
        check("load_done", int'(load_done), int'(e_done));
        check("load_err", int'(load_err), int'(e_err));
        check("words_loaded", int'(words_loaded), e_wl);
        bad_i = -1;
        for (int i = 0; i < int'(DEPTH); i++)
          if (bad_i < 0 && m_known[i] && dfo[i] != m_mem[i]) bad_i = i;
        if (bad_i >= 0) check($sformatf("mem[%0d]", bad_i), int'(dfo[bad_i]), int'(m_mem[bad_i]));
        else check("mem", 0, bad_i + 1);
        if (load_done) done_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Present one word (after optional idle gap) and hold it until accepted.
  task automatic send(input logic [IW-1:0] w, input int gap);
    bit rdy, fin;
    int n;
    if (gap > 0) begin in_valid = 1'b0; repeat (gap) tick(); end
    in_valid = 1'b1; in_data = w;
    fin = 0; n = 0;
    while (!fin) begin
      @(negedge clk); rdy = in_ready;
      tick();
      if (rdy) fin = 1;
      else begin
        n++;
        if (n > 40) begin
          total++; bad++;
          $display("FAIL send_timeout actual=no_ready required=ready word=%h", w);
          fin = 1;
        end
      end
    end
  endtask

  initial begin
    int d0;
    logic [IW-1:0] sum, w;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_prog_loading", int'(prog_loading), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_load_err", int'(load_err), 0);
    check("rst_words_loaded", int'(words_loaded), 0);
    reset = 1'b0;
    tick();

    // 1: header 3, back-to-back words, then an extra word that must stay unaccepted
    d0 = done_cnt;
    do_start();
    check("t1_loading_after_start", int'(prog_loading), 1);
    send(16'd3, 0); send(16'hA1B2, 0); send(16'h0003, 0); send(16'hFFFF, 0);
    if (CK) send(16'h5E4E, 0);
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    check("t1_mem0", int'(dfo[0]), 'hA1B2);
    check("t1_mem1", int'(dfo[1]), 'h0003);
    check("t1_mem2", int'(dfo[2]), 'hFFFF);
    check("t1_words_loaded", int'(words_loaded), 3);
    check("t1_done_pulses", done_cnt - d0, 1);

    // 2: header 0
    d0 = done_cnt;
    do_start();
    send(16'd0, 0);
    if (CK) send(16'd0, 0);
    in_valid = 1'b0;
    check("t2_load_done", int'(load_done), 1);
    repeat (2) tick();
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_mem0_kept", int'(dfo[0]), 'hA1B2);
    check("t2_words_loaded", int'(words_loaded), 0);

    // 3: header 1025 is too long
    do_start();
    send(16'd1025, 0);
    in_valid = 1'b0;
    check("t3_load_err", int'(load_err), 1);
    check("t3_loading_low", int'(prog_loading), 0);
    repeat (3) tick();
    check("t3_err_sticky", int'(load_err), 1);
    check("t3_mem0_kept", int'(dfo[0]), 'hA1B2);
    do_start();
    check("t3_err_cleared", int'(load_err), 0);
    send(16'd0, 0);
    if (CK) send(16'd0, 0);
    in_valid = 1'b0;
    repeat (2) tick();

    // 3b: non-zero upper header bits
    do_start();
    send(16'h8001, 0);
    in_valid = 1'b0;
    check("t3b_load_err", int'(load_err), 1);
    repeat (2) tick();

    // 4: header 16 with random valid gaps
    do_start();
    send(16'd16, 0);
    for (int i = 0; i < 16; i++) send(IW'(i), int'($urandom_range(0, 3)));
    if (CK) send(16'h0000, 1);
    in_valid = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 16; i++) check($sformatf("t4_mem%0d", i), int'(dfo[i]), i);
    check("t4_words_loaded", int'(words_loaded), 16);

    // 4b: maximum length 1024
    do_start();
    send(16'd1024, 0);
    sum = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w = IW'(i * 7) ^ 16'h3C00;
      sum = sum ^ w;
      send(w, 0);
    end
    if (CK) send(sum, 0);
    in_valid = 1'b0;
    repeat (2) tick();
    check("t4b_words_loaded", int'(words_loaded), 1024);
    check("t4b_mem1023", int'(dfo[1023]), int'(IW'(1023 * 7) ^ 16'h3C00));

    // 5: reset after 5 of 10 words
    do_start();
    send(16'd10, 0);
    for (int i = 0; i < 5; i++) send(16'h0100 + IW'(i), 0);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("t5_in_ready", int'(in_ready), 0);
    check("t5_prog_loading", int'(prog_loading), 0);
    check("t5_load_done", int'(load_done), 0);
    check("t5_load_err", int'(load_err), 0);
    check("t5_words_loaded", int'(words_loaded), 0);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) check($sformatf("t5_mem%0d", i), int'(dfo[i]), 'h100 + i);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum good, then bad
    d0 = done_cnt;
    do_start();
    send(16'd2, 0); send(16'h00F0, 0); send(16'h0F0F, 0); send(16'h0FFF, 0);
    in_valid = 1'b0;
    check("t6_load_done", int'(load_done), 1);
    repeat (2) tick();
    d0 = done_cnt;
    do_start();
    send(16'd2, 0); send(16'h00F0, 0); send(16'h0F0F, 0); send(16'h0000, 0);
    in_valid = 1'b0;
    check("t6_load_err", int'(load_err), 1);
    repeat (2) tick();
    check("t6_no_done", done_cnt - d0, 0);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
